tft_frame_engine: RTL and testbench

Parametrised single-clock TFT panel engine: it generates the pixel clock, raster counters and data enable for an RGB TFT panel and fetches each pixel from an external dual-port video RAM. It arbitrates touch/user pixel writes against a self-running full-screen clear, sequences panel power (VDD → display → backlight) and drives a programmable-duty backlight PWM. It sits between the drawing logic (touch front end) and the panel pins, and replaces the fixed-geometry driver with a resolution-, divider- and colour-depth-generic block.

---
 rtl/tft_frame_engine.sv | 204 ++++++++++++++++++++
 tb/tb_tft_frame_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tft_frame_engine.sv
// tft_frame_engine: pixel-clock divider, raster timing, VRAM pixel fetch,
// clear/user-write arbitration, panel power sequencing and backlight PWM.
module tft_frame_engine #(
  parameter int H_RES     = 480,
  parameter int V_RES     = 272,
  parameter int H_BLANK   = 45,
  parameter int V_BLANK   = 16,
  parameter int CLK_DIV   = 5,
  parameter int BPC       = 3,
  parameter int XY_W      = 12,
  parameter int ADDR_W    = 17,
  parameter int PWR_DELAY = 1024,
  parameter logic [3*BPC-1:0] CLEAR_COLOR = '0
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              wr_ena,
  input  logic [XY_W-1:0]   wr_x,
  input  logic [XY_W-1:0]   wr_y,
  input  logic [3*BPC-1:0]  wr_data,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [3*BPC-1:0]  vram_wdata,
  output logic [ADDR_W-1:0] vram_raddr,
  input  logic [3*BPC-1:0]  vram_rdata,
  input  logic [7:0]        backlight_duty,
  output logic              tft_clk,
  output logic              tft_vdd,
  output logic              tft_display,
  output logic              tft_backlight,
  output logic              tft_data_ena,
  output logic [7:0]        tft_red,
  output logic [7:0]        tft_green,
  output logic [7:0]        tft_blue,
  output logic [XY_W-1:0]   x,
  output logic [XY_W-1:0]   y,
  output logic              new_frame
);

  localparam int PW    = 3 * BPC;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PWR_W = $clog2(PWR_DELAY + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(1);
  localparam logic [XY_W-1:0]   H_ACT    = XY_W'(H_RES);
  localparam logic [XY_W-1:0]   V_ACT    = XY_W'(V_RES);
  localparam logic [XY_W-1:0]   H_LAST   = XY_W'(H_RES + H_BLANK - 1);
  localparam logic [XY_W-1:0]   V_LAST   = XY_W'(V_RES + V_BLANK - 1);
  localparam logic [ADDR_W-1:0] H_MUL    = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [PWR_W-1:0]  PWR_LAST = PWR_W'(PWR_DELAY - 1);

  typedef enum logic [1:0] {P_OFF, P_VDD, P_DISP, P_RUN} pwr_state_t;
  typedef enum logic       {C_IDLE, C_CLEAR}             clr_state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             tick;
  logic             active;
  logic [PWR_W-1:0] pwr_cnt;
  logic [7:0]       pwm_cnt;
  pwr_state_t       pwr_state;
  clr_state_t       clr_state;

  // Replicate a BPC-bit channel across 8 bits, MSB first (3'b101 -> 8'hB6).
  function automatic logic [7:0] expand(input logic [BPC-1:0] c);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++)
      r[7-i] = c[BPC-1-(i % BPC)];
    return r;
  endfunction

  assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  assign tick     = (div_cnt == DIV_LAST);
  assign active   = (x < H_ACT) && (y < V_ACT);

  // Read address follows the raster directly so data returns by div_cnt==1.
  assign vram_raddr = active ? (ADDR_W'(y) * H_MUL + ADDR_W'(x)) : '0;

  assign tft_backlight = (pwr_state == P_RUN) && (pwm_cnt < backlight_duty);

  // Pixel divider, pixel clock and raster counters.
  always_ff @(posedge cclk) begin
    if (rst) begin
      div_cnt   <= '0;
      tft_clk   <= 1'b0;
      x         <= '0;
      y         <= '0;
      new_frame <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      // tft_clk is registered from the next divider value so it is high
      // exactly in the cycles where div_cnt > CLK_DIV/2.
      tft_clk   <= (div_next > DIV_HALF);
      new_frame <= tick && (x == H_LAST) && (y == V_LAST);
      if (tick) begin
        if (x == H_LAST) begin
          x <= '0;
          y <= (y == V_LAST) ? '0 : y + XY_W'(1);
        end else begin
          x <= x + XY_W'(1);
        end
      end
    end
  end

  // Panel data register, loaded once per pixel period after VRAM read data settles.
  always_ff @(posedge cclk) begin
    if (rst) begin
      tft_data_ena <= 1'b0;
      tft_red      <= '0;
      tft_green    <= '0;
      tft_blue     <= '0;
    end else if (div_cnt == DIV_LOAD) begin
      tft_data_ena <= active && tft_display;
      tft_red      <= active ? expand(vram_rdata[PW-1 -: BPC])    : '0;
      tft_green    <= active ? expand(vram_rdata[2*BPC-1 -: BPC]) : '0;
      tft_blue     <= active ? expand(vram_rdata[BPC-1:0])        : '0;
    end
  end

  // Power sequencer: OFF -> VDD -> DISP -> RUN, PWR_DELAY cycles per step.
  always_ff @(posedge cclk) begin
    if (rst) begin
      pwr_state   <= P_OFF;
      pwr_cnt     <= '0;
      tft_vdd     <= 1'b0;
      tft_display <= 1'b0;
    end else if (pwr_state != P_RUN) begin
      if (pwr_cnt == PWR_LAST) begin
        pwr_cnt <= '0;
        case (pwr_state)
          P_OFF: begin
            pwr_state <= P_VDD;
            tft_vdd   <= 1'b1;
          end
          P_VDD: begin
            pwr_state   <= P_DISP;
            tft_display <= 1'b1;
          end
          default: pwr_state <= P_RUN;
        endcase
      end else begin
        pwr_cnt <= pwr_cnt + PWR_W'(1);
      end
    end
  end

  // Free-running backlight PWM counter.
  always_ff @(posedge cclk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  // Clear sequencer and user-write arbitration on the VRAM write port.
  always_ff @(posedge cclk) begin
    if (rst) begin
      clr_state  <= C_IDLE;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
    end else begin
      clear_done <= 1'b0;
      case (clr_state)
        C_IDLE: begin
          if (clear_req) begin
            clr_state  <= C_CLEAR;
            clear_busy <= 1'b1;
            vram_we    <= 1'b1;
            vram_waddr <= '0;
            vram_wdata <= CLEAR_COLOR;
          end else if (wr_ena && (wr_x < H_ACT) && (wr_y < V_ACT)) begin
            vram_we    <= 1'b1;
            vram_waddr <= ADDR_W'(wr_y) * H_MUL + ADDR_W'(wr_x);
            vram_wdata <= wr_data;
          end else begin
            vram_we <= 1'b0;
          end
        end
        C_CLEAR: begin
          // vram_waddr doubles as the clear pointer: it holds the address
          // being written this cycle.
          if (vram_waddr == CLR_LAST) begin
            clr_state  <= C_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            vram_we    <= 1'b0;
          end else begin
            vram_waddr <= vram_waddr + ADDR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_frame_engine.sv
// Directed bench for tft_frame_engine on a 4x2 raster (6x3 total, CLK_DIV 4).
module tb_tft_frame_engine;

  localparam int PW = 9;
  localparam int AW = 8;
  localparam int XW = 12;

  logic          cclk = 1'b0;
  logic          rst;
  logic          wr_ena;
  logic [XW-1:0] wr_x, wr_y;
  logic [PW-1:0] wr_data;
  logic          clear_req;
  logic          clear_busy, clear_done;
  logic          vram_we;
  logic [AW-1:0] vram_waddr, vram_raddr;
  logic [PW-1:0] vram_wdata, vram_rdata;
  logic [7:0]    backlight_duty;
  logic          tft_clk, tft_vdd, tft_display, tft_backlight, tft_data_ena;
  logic [7:0]    tft_red, tft_green, tft_blue;
  logic [XW-1:0] x, y;
  logic          new_frame;

  int total = 0;
  int bad   = 0;
  int n_ena, n_clk, n_nf, n_bl, n_done;

  tft_frame_engine #(
    .H_RES(4), .V_RES(2), .H_BLANK(2), .V_BLANK(1), .CLK_DIV(4), .BPC(3),
    .XY_W(XW), .ADDR_W(AW), .PWR_DELAY(4), .CLEAR_COLOR(9'h155)
  ) dut (
    .cclk(cclk), .rst(rst), .wr_ena(wr_ena), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .clear_req(clear_req), .clear_busy(clear_busy),
    .clear_done(clear_done), .vram_we(vram_we), .vram_waddr(vram_waddr),
    .vram_wdata(vram_wdata), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
    .backlight_duty(backlight_duty), .tft_clk(tft_clk), .tft_vdd(tft_vdd),
    .tft_display(tft_display), .tft_backlight(tft_backlight),
    .tft_data_ena(tft_data_ena), .tft_red(tft_red), .tft_green(tft_green),
    .tft_blue(tft_blue), .x(x), .y(y), .new_frame(new_frame)
  );

  always #5 cclk = ~cclk;

  // VRAM read-side contents: address 1 = 101_011_000, address 3 = 011_100_011.
  function automatic logic [PW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      8'd1:    return 9'h158;
      8'd3:    return 9'h0E3;
      default: return {a[2:0], ~a[2:0], a[2:0]};
    endcase
  endfunction

  always @(posedge cclk) vram_rdata <= rom(vram_raddr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    clear_req = 1'b0; backlight_duty = 8'd255;
    n_ena = 0; n_clk = 0; n_nf = 0; n_bl = 0; n_done = 0;

    repeat (2) step();
    check("reset_panel", {x, y, tft_clk, tft_vdd, tft_display, tft_data_ena,
                          new_frame, tft_backlight, tft_red, tft_green, tft_blue}, '0);
    check("reset_vram", {clear_busy, clear_done, vram_we, vram_waddr, vram_wdata}, '0);
    rst = 1'b0;

    // Raster / power / pixel path, edges counted from reset release.
    for (int e = 1; e <= 150; e++) begin
      step();
      if (e >= 73 && e <= 144) begin
        n_ena += int'(tft_data_ena);
        n_clk += int'(tft_clk);
      end
      n_nf += int'(new_frame);
      case (e)
        2:  check("tclk_lo", tft_clk, 1'b0);
        3:  begin
              check("tclk_hi", tft_clk, 1'b1);
              check("vdd_pre", tft_vdd, 1'b0);
            end
        4:  begin
              check("vdd_on", tft_vdd, 1'b1);
              check("x_tick", x, 12'd1);
              check("raddr_1", vram_raddr, 8'd1);
            end
        6:  begin
              check("pix10_rgb", {tft_red, tft_green, tft_blue}, 24'hB66D00);
              check("ena_disp_off", tft_data_ena, 1'b0);
            end
        7:  check("disp_pre", tft_display, 1'b0);
        8:  check("disp_on", tft_display, 1'b1);
        11: check("bl_pre_run", tft_backlight, 1'b0);
        12: check("bl_run", tft_backlight, 1'b1);
        14: check("pix30", {tft_data_ena, tft_red, tft_green, tft_blue}, 25'h16D926D);
        16: check("raddr_blank", vram_raddr, 8'd0);
        18: check("pix_blank", {tft_data_ena, tft_red, tft_green, tft_blue}, 25'h0);
        24: check("xy_line1", {x, y}, {12'd0, 12'd1});
        71: check("nf_before", new_frame, 1'b0);
        72: check("nf_pulse", new_frame, 1'b1);
        73: check("nf_after", new_frame, 1'b0);
        78: check("pix10_f2", {tft_data_ena, tft_red, tft_green, tft_blue}, 25'h1B66D00);
        default: ;
      endcase
    end
    check("ena_per_frame", n_ena, 32);
    check("tclk_per_frame", n_clk, 18);
    check("nf_count", n_nf, 2);

    // User writes.
    wr_ena = 1'b1; wr_x = 12'd2; wr_y = 12'd1; wr_data = 9'h1FF;
    step();
    check("wr_21", {vram_we, vram_waddr, vram_wdata}, {1'b1, 8'd6, 9'h1FF});
    wr_x = 12'd4; wr_y = 12'd0; wr_data = 9'h0F0;
    step();
    check("wr_x_oob", vram_we, 1'b0);
    wr_x = 12'd0; wr_y = 12'd2;
    step();
    check("wr_y_oob", vram_we, 1'b0);
    wr_x = 12'd3; wr_y = 12'd1; wr_data = 9'h0C3;
    step();
    check("wr_last", {vram_we, vram_waddr, vram_wdata}, {1'b1, 8'd7, 9'h0C3});
    wr_ena = 1'b0;
    step();
    check("wr_idle", vram_we, 1'b0);

    // Full clear with a competing user write held throughout.
    clear_req = 1'b1; wr_ena = 1'b1; wr_x = 12'd1; wr_y = 12'd1; wr_data = 9'h0AA;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) clear_req = 1'b0;
      if (k == 7) wr_ena = 1'b0;
      check($sformatf("clr_%0d", k), {clear_busy, vram_we, vram_waddr, vram_wdata},
            {1'b1, 1'b1, 8'(k), 9'h155});
    end
    step();
    check("clr_end", {clear_done, clear_busy, vram_we}, 3'b100);
    step();
    check("clr_done_pulse", clear_done, 1'b0);

    // Clear aborted by reset on the third write.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    step();
    check("clr2_third", {clear_busy, vram_waddr}, {1'b1, 8'd2});
    rst = 1'b1;
    step();
    check("abort_vram", {clear_busy, clear_done, vram_we, vram_waddr, vram_wdata}, '0);
    check("abort_panel", {x, y, tft_clk, tft_vdd, tft_display, tft_data_ena,
                          new_frame, tft_backlight, tft_red}, '0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_done += int'(clear_done);
    end
    check("abort_no_done", n_done, 0);

    // Backlight PWM duty.
    backlight_duty = 8'd64;
    for (int i = 0; i < 256; i++) begin
      step();
      n_bl += int'(tft_backlight);
    end
    check("pwm_64", n_bl, 64);
    backlight_duty = 8'd0;
    n_bl = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      n_bl += int'(tft_backlight);
    end
    check("pwm_0", n_bl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
